// File: rtl/stopwatch_lap.sv
// stopwatch_lap: BCD MM:SS.cc stopwatch/countdown with lap hold, preset load and 7-segment view select
module stopwatch_lap #(
    parameter int SPN     = 240000,
    parameter int MAX_MIN = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       b_run,
    input  logic       b_clr,
    input  logic       dir,
    input  logic       ld,
    input  logic [7:0] ld_min,
    input  logic [7:0] ld_sec,
    input  logic       view,
    output logic [6:0] seg_0,
    output logic [6:0] seg_1,
    output logic [6:0] seg_2,
    output logic [6:0] seg_3,
    output logic       s_run,
    output logic       s_hld,
    output logic       s_end
);
    localparam int PW = $clog2(SPN);
    localparam logic [7:0] MAX_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

    logic            r_run_q, r_clr_q, r_run, r_hld, r_end, r_dir;
    logic [PW-1:0]   r_pre;
    logic [5:0][3:0] r_t, r_disp;
    logic [3:0][6:0] r_seg;
    logic [5:0][3:0] w_nt, w_ld_t, w_t1;
    logic [3:0][3:0] w_view;
    logic [3:0]      w_m1, w_m0;
    logic [7:0]      w_lm_bin;
    logic            w_run_ev, w_clr_ev, w_tick, w_cy, w_hit;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0: f_seg = 7'h3F;
            4'd1: f_seg = 7'h06;
            4'd2: f_seg = 7'h5B;
            4'd3: f_seg = 7'h4F;
            4'd4: f_seg = 7'h66;
            4'd5: f_seg = 7'h6D;
            4'd6: f_seg = 7'h7D;
            4'd7: f_seg = 7'h07;
            4'd8: f_seg = 7'h7F;
            4'd9: f_seg = 7'h6F;
            default: f_seg = 7'h00;
        endcase
    endfunction

    assign w_run_ev = b_run & ~r_run_q;
    assign w_clr_ev = b_clr & ~r_clr_q;
    assign w_tick   = r_pre == PW'(SPN - 1);
    assign w_hit    = w_tick && r_dir && w_nt == '0;

    // digits 0..3 are cs units, cs tens, sec units, sec tens; 4..5 are minutes
    always_comb begin
        w_nt = r_t;
        w_cy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_cy)
                w_nt[i] = r_dir ? (r_t[i] == 4'd0 ? (i == 3 ? 4'd5 : 4'd9) : r_t[i] - 4'd1)
                                : (r_t[i] == (i == 3 ? 4'd5 : 4'd9) ? 4'd0 : r_t[i] + 4'd1);
            w_cy = w_cy & (r_dir ? r_t[i] == 4'd0 : r_t[i] == (i == 3 ? 4'd5 : 4'd9));
        end
        if (w_cy)
            w_nt[5:4] = r_dir ? (r_t[5:4] == 8'h00 ? MAX_BCD
                               : r_t[4] == 4'd0 ? {r_t[5] - 4'd1, 4'd9} : {r_t[5], r_t[4] - 4'd1})
                              : (r_t[5:4] == MAX_BCD ? 8'h00
                               : r_t[4] == 4'd9 ? {r_t[5] + 4'd1, 4'd0} : {r_t[5], r_t[4] + 4'd1});
    end

    always_comb begin
        w_m1     = ld_min[7:4] > 4'd9 ? 4'd9 : ld_min[7:4];
        w_m0     = ld_min[3:0] > 4'd9 ? 4'd9 : ld_min[3:0];
        w_lm_bin = {4'd0, w_m1} * 8'd10 + {4'd0, w_m0};
        w_ld_t   = {w_lm_bin > 8'(MAX_MIN) ? MAX_BCD : {w_m1, w_m0},
                    ld_sec[7:4] > 4'd5 ? 4'd5 : ld_sec[7:4],
                    ld_sec[3:0] > 4'd9 ? 4'd9 : ld_sec[3:0], 8'h00};
        w_t1     = ld ? w_ld_t : w_clr_ev ? '0 : r_t;
        w_view   = view ? r_disp[3:0] : r_disp[5:2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_q <= 1'b0;
            r_clr_q <= 1'b0;
            r_run   <= 1'b0;
            r_hld   <= 1'b0;
            r_end   <= 1'b0;
            r_dir   <= 1'b0;
            r_pre   <= '0;
            r_t     <= '0;
            r_disp  <= '0;
            r_seg   <= {4{7'h3F}};
        end else begin
            r_run_q <= b_run;
            r_clr_q <= b_clr;
            r_disp  <= r_hld ? r_disp : r_t;
            for (int d = 0; d < 4; d++) r_seg[d] <= f_seg(w_view[d]);
            if (r_run) begin
                if (w_clr_ev) r_hld <= ~r_hld;
                r_pre <= w_tick ? '0 : r_pre + PW'(1);
                if (w_tick) r_t <= w_nt;
                if (w_run_ev || w_hit) r_run <= 1'b0;
                if (w_hit) r_end <= 1'b1;
            end else begin
                if (ld || w_clr_ev) begin
                    r_t   <= w_t1;
                    r_pre <= '0;
                end
                if (!ld && w_clr_ev) begin
                    r_hld <= 1'b0;
                    r_end <= 1'b0;
                end
                // a countdown may not start from zero time
                if (w_run_ev && !(dir && w_t1 == '0)) begin
                    r_run <= 1'b1;
                    r_dir <= dir;
                    r_end <= 1'b0;
                end
            end
        end
    end

    assign seg_0 = r_seg[0];
    assign seg_1 = r_seg[1];
    assign seg_2 = r_seg[2];
    assign seg_3 = r_seg[3];
    assign s_run = r_run;
    assign s_hld = r_hld;
    assign s_end = r_end;
endmodule

// File: tb/tb_stopwatch_lap.sv
// tb_stopwatch_lap: three stopwatch_lap instances (MAX_MIN 99/1/50, SPN 4) checked through a due-cycle scoreboard
module tb_stopwatch_lap;
    localparam logic [6:0] SEG_LUT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    localparam logic [3:0][6:0] ZERO = {4{7'h3F}};

    typedef struct {
        string           n;
        int              u;
        int              due;
        logic [3:0][6:0] sg;
        logic            r, h, e;
    } exp_t;

    typedef struct {
        logic [7:0]      lm, ls;
        logic            v;
        logic [3:0][6:0] e0, e2;
    } vec_t;

    logic clk = 1'b0, rst, b_run, b_clr, dir, ld, view;
    logic [7:0] ld_min, ld_sec;
    logic [2:0][3:0][6:0] sg;
    logic [2:0] fr, fh, fe;
    int cyc = 0, checks = 0, failures = 0;
    exp_t q[$];
    vec_t tbl[7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stopwatch_lap #(.SPN(4), .MAX_MIN(99)) u0 (.clk(clk), .rst(rst), .b_run(b_run), .b_clr(b_clr), .dir(dir), .ld(ld),
        .ld_min(ld_min), .ld_sec(ld_sec), .view(view), .seg_0(sg[0][0]), .seg_1(sg[0][1]), .seg_2(sg[0][2]),
        .seg_3(sg[0][3]), .s_run(fr[0]), .s_hld(fh[0]), .s_end(fe[0]));
    stopwatch_lap #(.SPN(4), .MAX_MIN(1)) u1 (.clk(clk), .rst(rst), .b_run(b_run), .b_clr(b_clr), .dir(dir), .ld(ld),
        .ld_min(ld_min), .ld_sec(ld_sec), .view(view), .seg_0(sg[1][0]), .seg_1(sg[1][1]), .seg_2(sg[1][2]),
        .seg_3(sg[1][3]), .s_run(fr[1]), .s_hld(fh[1]), .s_end(fe[1]));
    stopwatch_lap #(.SPN(4), .MAX_MIN(50)) u2 (.clk(clk), .rst(rst), .b_run(b_run), .b_clr(b_clr), .dir(dir), .ld(ld),
        .ld_min(ld_min), .ld_sec(ld_sec), .view(view), .seg_0(sg[2][0]), .seg_1(sg[2][1]), .seg_2(sg[2][2]),
        .seg_3(sg[2][3]), .s_run(fr[2]), .s_hld(fh[2]), .s_end(fe[2]));

    function automatic logic [3:0][6:0] tm(int m, int s, int cs, bit v);
        return v ? {SEG_LUT[s / 10], SEG_LUT[s % 10], SEG_LUT[cs / 10], SEG_LUT[cs % 10]}
                 : {SEG_LUT[m / 10], SEG_LUT[m % 10], SEG_LUT[s / 10], SEG_LUT[s % 10]};
    endfunction

    function automatic logic [3:0][6:0] tk(int k, bit v);
        return tm(k / 6000, (k / 100) % 60, k % 100, v);
    endfunction

    task automatic push(input string n, input int u, input int due, input logic [3:0][6:0] s,
                        input logic r, input logic h, input logic e);
        exp_t x;
        x.n = n; x.u = u; x.due = due; x.sg = s; x.r = r; x.h = h; x.e = e;
        q.push_back(x);
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        for (int k = q.size() - 1; k >= 0; k--) begin
            if (q[k].due <= cyc) begin
                checks++;
                if (sg[q[k].u] !== q[k].sg || fr[q[k].u] !== q[k].r || fh[q[k].u] !== q[k].h || fe[q[k].u] !== q[k].e) begin
                    failures++;
                    $display("FAIL %s dut%0d cyc=%0d: got seg=%h run=%b hld=%b end=%b, expected seg=%h run=%b hld=%b end=%b",
                             q[k].n, q[k].u, cyc, sg[q[k].u], fr[q[k].u], fh[q[k].u], fe[q[k].u],
                             q[k].sg, q[k].r, q[k].h, q[k].e);
                end
                q.delete(k);
            end
        end
    end

    initial begin
        int s, c, g;
        int ks[9] = '{0, 1, 9, 10, 99, 100, 101, 400, 401};
        tbl[0] = '{8'h00, 8'h00, 1'b0, ZERO, ZERO};
        tbl[1] = '{8'h12, 8'h34, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, {7'h06, 7'h5B, 7'h4F, 7'h66}};
        tbl[2] = '{8'h56, 8'h57, 1'b0, {7'h6D, 7'h7D, 7'h6D, 7'h07}, {7'h6D, 7'h3F, 7'h6D, 7'h07}};
        tbl[3] = '{8'h89, 8'h08, 1'b0, {7'h7F, 7'h6F, 7'h3F, 7'h7F}, {7'h6D, 7'h3F, 7'h3F, 7'h7F}};
        tbl[4] = '{8'hA7, 8'h8F, 1'b0, {7'h6F, 7'h07, 7'h6D, 7'h6F}, {7'h6D, 7'h3F, 7'h6D, 7'h6F}};
        tbl[5] = '{8'h12, 8'h34, 1'b1, {7'h4F, 7'h66, 7'h3F, 7'h3F}, {7'h4F, 7'h66, 7'h3F, 7'h3F}};
        tbl[6] = '{8'h3C, 8'hF5, 1'b0, {7'h4F, 7'h6F, 7'h6D, 7'h6D}, {7'h4F, 7'h6F, 7'h6D, 7'h6D}};
        rst = 1'b1; b_run = 1'b0; b_clr = 1'b0; dir = 1'b0; ld = 1'b0; view = 1'b0; ld_min = '0; ld_sec = '0;

        tick_to(2);
        for (int u = 0; u < 3; u++) push("reset", u, 3, ZERO, 0, 0, 0);
        tick_to(3); rst = 1'b0;
        push("idle", 0, 6, ZERO, 0, 0, 0);

        tick_to(10); s = cyc; view = 1'b1; dir = 1'b0; b_run = 1'b1;
        push("start", 0, s + 1, ZERO, 1, 0, 0);
        foreach (ks[i]) push("up", 0, s + 3 + 4 * ks[i], tk(ks[i], 1), 1, 0, 0);
        push("lap_set", 0, s + 1272, tm(0, 3, 17, 1), 1, 1, 0);
        push("lap_frozen", 0, s + 1280, tm(0, 3, 17, 1), 1, 1, 0);
        push("lap_rel_wait", 0, s + 1302, tm(0, 3, 17, 1), 1, 0, 0);
        push("lap_rel_live", 0, s + 1303, tm(0, 3, 25, 1), 1, 0, 0);
        tick_to(s + 3); b_run = 1'b0;
        tick_to(s + 1270); b_clr = 1'b1;
        tick_to(s + 1274); b_clr = 1'b0;
        tick_to(s + 1300); b_clr = 1'b1;
        tick_to(s + 1304); b_clr = 1'b0;
        tick_to(s + 1610); b_run = 1'b1;
        push("stop", 0, s + 1611, tk(402, 1), 0, 0, 0);
        tick_to(s + 1614); b_run = 1'b0; view = 1'b0;
        push("view0", 0, s + 1616, tk(402, 0), 0, 0, 0);
        tick_to(s + 1620); b_clr = 1'b1;
        push("clear", 0, s + 1623, ZERO, 0, 0, 0);
        tick_to(s + 1624); b_clr = 1'b0;

        tick_to(s + 1630); s = cyc; ld = 1'b1; ld_min = 8'h00; ld_sec = 8'h02; dir = 1'b1; b_run = 1'b1; view = 1'b1;
        push("dn_go", 0, s + 1, ZERO, 1, 0, 0);
        push("dn_load", 0, s + 6, tm(0, 2, 0, 1), 1, 0, 0);
        push("dn_borrow", 0, s + 7, tm(0, 1, 99, 1), 1, 0, 0);
        push("dn_last", 0, s + 800, tm(0, 0, 1, 1), 1, 0, 0);
        for (int u = 0; u < 3; u++) push("dn_end", u, s + 801, tm(0, 0, 1, 1), 0, 0, 1);
        push("dn_zero", 0, s + 803, ZERO, 0, 0, 1);
        tick_to(s + 1); ld = 1'b0;
        tick_to(s + 3); b_run = 1'b0;
        tick_to(s + 820); b_run = 1'b1;
        push("dn_ignore", 0, s + 825, ZERO, 0, 0, 1);
        tick_to(s + 824); b_run = 1'b0;
        tick_to(s + 830); b_clr = 1'b1;
        push("dn_clear", 0, s + 833, ZERO, 0, 0, 0);
        tick_to(s + 834); b_clr = 1'b0;

        tick_to(s + 840); s = cyc; ld = 1'b1; ld_min = 8'h01; ld_sec = 8'h59; dir = 1'b0; b_run = 1'b1; view = 1'b0;
        push("roll_load", 1, s + 6, tm(1, 59, 0, 0), 1, 0, 0);
        push("roll_pre", 1, s + 402, tm(1, 59, 0, 0), 1, 0, 0);
        push("roll_wrap", 1, s + 403, ZERO, 1, 0, 0);
        push("roll_nowrap", 0, s + 403, tm(2, 0, 0, 0), 1, 0, 0);
        push("roll_nowrap50", 2, s + 403, tm(2, 0, 0, 0), 1, 0, 0);
        push("roll_keep", 1, s + 450, ZERO, 1, 0, 0);
        tick_to(s + 1); ld = 1'b0;
        tick_to(s + 3); b_run = 1'b0;
        tick_to(s + 460); b_run = 1'b1;
        push("roll_stop", 0, s + 461, tm(2, 0, 14, 0), 0, 0, 0);
        tick_to(s + 464); b_run = 1'b0;
        tick_to(s + 470); b_clr = 1'b1;
        push("roll_clear", 0, s + 473, ZERO, 0, 0, 0);
        tick_to(s + 474); b_clr = 1'b0;

        for (int i = 0; i < 7; i++) begin
            c = cyc; ld = 1'b1; ld_min = tbl[i].lm; ld_sec = tbl[i].ls; view = tbl[i].v;
            push($sformatf("load%0d", i), 0, c + 3, tbl[i].e0, 0, 0, 0);
            push($sformatf("load%0d", i), 2, c + 3, tbl[i].e2, 0, 0, 0);
            tick_to(c + 1); ld = 1'b0;
            tick_to(c + 5);
        end
        c = cyc; ld = 1'b1; ld_min = 8'hA7; ld_sec = 8'h8F; view = 1'b0;
        push("clamp_max1", 1, c + 3, tm(1, 59, 0, 0), 0, 0, 0);
        tick_to(c + 1); ld = 1'b0;
        tick_to(c + 5);

        c = cyc; view = 1'b1; dir = 1'b0; b_clr = 1'b1; b_run = 1'b1;
        push("clr_run", 0, c + 1, tm(97, 59, 0, 1), 1, 0, 0);
        push("clr_run_zero", 0, c + 3, ZERO, 1, 0, 0);
        push("clr_run_tick", 0, c + 7, tm(0, 0, 1, 1), 1, 0, 0);
        tick_to(c + 2); b_clr = 1'b0; b_run = 1'b0;
        tick_to(c + 20); b_clr = 1'b1;
        push("lap2", 0, c + 22, tm(0, 0, 4, 1), 1, 1, 0);
        tick_to(c + 22); b_clr = 1'b0;
        tick_to(c + 30); rst = 1'b1;
        for (int u = 0; u < 3; u++) push("mid_reset", u, c + 31, ZERO, 0, 0, 0);
        tick_to(c + 31); rst = 1'b0;
        checks++;
        if (sg !== {3{ZERO}}) begin
            failures++;
            $display("FAIL mid_reset_seg: got seg=%h", sg);
        end
        checks++;
        if (fr !== 3'b000 || fh !== 3'b000 || fe !== 3'b000) begin
            failures++;
            $display("FAIL mid_reset_flags: got run=%b hld=%b end=%b", fr, fh, fe);
        end
        push("post_reset", 0, c + 40, ZERO, 0, 0, 0);

        g = 0;
        while (q.size() > 0 && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        foreach (q[k]) begin
            checks++;
            failures++;
            $display("FAIL %s dut%0d: expectation due at cyc=%0d never compared", q[k].n, q[k].u, q[k].due);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
